// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, divisor defaults and the
// status-word bit layout used by the transmitter and the bus decoder.
package uart_pkg;

    localparam int unsigned DIV_W_DEF   = 16;
    localparam int unsigned MIN_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int unsigned STAT_READY_BIT   = 0;
    localparam int unsigned STAT_OVERRUN_BIT = 1;
    localparam int unsigned STAT_FERR_BIT    = 2;

    function automatic logic [7:0] status_word(input logic ready,
                                               input logic overrun,
                                               input logic ferr);
        logic [7:0] w;
        w                   = '0;
        w[STAT_READY_BIT]   = ready;
        w[STAT_OVERRUN_BIT] = overrun;
        w[STAT_FERR_BIT]    = ferr;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial pin, divisor and the CPU-facing
// holding register / flag / interrupt signals.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
);

    logic             rxd;
    logic [DIV_W-1:0] clkdiv;
    logic             rxack;
    logic [7:0]       rxdata;
    logic             rxready;
    logic             rxint;
    logic             overrun;
    logic             framing_err;

    // Receiver end.
    modport slave (
        input  rxd,
        input  clkdiv,
        input  rxack,
        output rxdata,
        output rxready,
        output rxint,
        output overrun,
        output framing_err
    );

    // Pin / CPU end.
    modport master (
        output rxd,
        output clkdiv,
        output rxack,
        input  rxdata,
        input  rxready,
        input  rxint,
        input  overrun,
        input  framing_err
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; the reset value
// matches the idle level of the line being synchronized.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling at a programmable divisor, holding
// register with ready/overrun/framing-error flags and a per-byte interrupt.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
    input  logic      clk,
    input  logic      reset_in,
    uart_rx_if.slave  bus
);

    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic             rxd_s;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_eff;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rxdata_q, rxdata_d;
    logic             rxready_q, rxready_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;
    logic             tick;
    logic             deliver;
    logic             ferr_set;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(reset_in),
        .d_i   (bus.rxd),
        .q_o   (rxd_s)
    );

    assign div_eff = (bus.clkdiv < MIN_DIV_V) ? MIN_DIV_V : bus.clkdiv;
    assign tick    = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!rxd_s) state_d = ST_START;
            ST_START: if (tick) state_d = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && (bitcnt_q == 3'd7)) state_d = ST_STOP;
            ST_STOP:  if (tick) state_d = rxd_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxd_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter holds at zero when idle, so START/DATA/STOP always see a fresh load.
    always_comb begin
        div_d    = div_q;
        cnt_d    = tick ? cnt_q : cnt_q - ONE;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    div_d = div_eff;
                    cnt_d = (div_eff >> 1) - ONE;
                end
            end
            ST_START: begin
                if (tick && !rxd_s) begin
                    cnt_d    = div_q - ONE;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d  = {rxd_s, shreg_q[7:1]};
                    cnt_d    = div_q - ONE;
                    bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    deliver  = rxd_s;
                    ferr_set = !rxd_s;
                end
            end
            ST_BREAK: ;
            default: ;
        endcase
    end

    // A delivery beats a coincident rxack; a framing error beats it too.
    always_comb begin
        rxdata_d  = deliver ? shreg_q : rxdata_q;
        rxready_d = deliver | (rxready_q & ~bus.rxack);
        overrun_d = (overrun_q & ~bus.rxack) | (deliver & rxready_q & ~bus.rxack);
        ferr_d    = (ferr_q & ~bus.rxack) | ferr_set;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            div_q     <= '0;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            rxdata_q  <= '0;
            rxready_q <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            rxdata_q  <= rxdata_d;
            rxready_q <= rxready_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.rxdata      = rxdata_q;
    assign bus.rxready     = rxready_q;
    assign bus.rxint       = deliver;
    assign bus.overrun     = overrun_q;
    assign bus.framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of whole frames plus hand-written
// sequences for back-to-back, glitch, coincident-ack and mid-frame reset cases.
module tb_uart_rx;

    logic clk;
    logic rst_n;

    uart_rx_if #(.DIV_W(16)) bus ();

    uart_rx #(
        .DIV_W  (16),
        .MIN_DIV(4)
    ) dut (
        .clk     (clk),
        .reset_in(rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] clkdiv;
        int unsigned cpb;
        logic [7:0]  data;
        int unsigned stop_low;
        bit          ack_first;
        logic [7:0]  e_data;
        bit          e_ready;
        bit          e_ovr;
        bit          e_ferr;
        int unsigned e_int;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned nint = 0;
    int unsigned int_cyc = 0;
    int unsigned start_cyc = 0;
    bit ack_on_int = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rxint === 1'b1) begin
            nint    <= nint + 1;
            int_cyc <= cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
        if (ack_on_int) bus.rxack = bus.rxint;
    endtask

    task automatic drive_level(input logic v, input int unsigned n);
        bus.rxd = v;
        repeat (n) tick_clk();
    endtask

    task automatic send_frame(input logic [7:0] b, input int unsigned cpb,
                              input int unsigned stop_low);
        start_cyc = cyc;
        drive_level(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_level(b[i], cpb);
        if (stop_low > 0) drive_level(1'b0, stop_low * cpb);
        drive_level(1'b1, cpb);
    endtask

    task automatic ack_pulse();
        bus.rxack = 1'b1;
        tick_clk();
        bus.rxack = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] d, input bit r,
                            input bit o, input bit f);
        chk({tag, ".rxdata"},      32'(bus.rxdata),      32'(d));
        chk({tag, ".rxready"},     32'(bus.rxready),     32'(r));
        chk({tag, ".overrun"},     32'(bus.overrun),     32'(o));
        chk({tag, ".framing_err"}, 32'(bus.framing_err), 32'(f));
    endtask

    vec_t vecs[9];

    initial begin
        int unsigned n0;
        int unsigned lat;

        vecs[0] = '{16'd16, 16, 8'h55, 0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{16'd16, 16, 8'hA3, 0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{16'd16, 16, 8'h3C, 0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1};
        vecs[3] = '{16'd16, 16, 8'h00, 3, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{16'd16, 16, 8'h7E, 0, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{16'd2,   4, 8'hF0, 0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{16'd7,   7, 8'h81, 0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1};
        vecs[7] = '{16'd0,   4, 8'h5A, 0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1};
        vecs[8] = '{16'd16, 16, 8'hFF, 0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1};

        rst_n      = 1'b0;
        bus.rxd    = 1'b1;
        bus.rxack  = 1'b0;
        bus.clkdiv = 16'd16;
        repeat (3) tick_clk();
        chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.rxint", 32'(bus.rxint), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick_clk();

        for (int i = 0; i < 9; i++) begin
            bus.clkdiv = vecs[i].clkdiv;
            if (vecs[i].ack_first) ack_pulse();
            repeat (2) tick_clk();
            n0 = nint;
            send_frame(vecs[i].data, vecs[i].cpb, vecs[i].stop_low);
            drive_level(1'b1, 2 * vecs[i].cpb + 8);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ready,
                     vecs[i].e_ovr, vecs[i].e_ferr);
            chk($sformatf("vec%0d.nint", i), 32'(nint - n0), 32'(vecs[i].e_int));
            if (vecs[i].e_int == 1 && vecs[i].cpb == 16) begin
                lat = int_cyc - start_cyc;
                chk($sformatf("vec%0d.latency_ok(lat=%0d)", i, lat),
                    32'(lat >= 152 && lat <= 156), 32'd1);
            end
        end

        // back-to-back frames, no idle between them, no ack
        bus.clkdiv = 16'd16;
        ack_pulse();
        repeat (2) tick_clk();
        n0 = nint;
        send_frame(8'hA3, 16, 0);
        send_frame(8'h3C, 16, 0);
        drive_level(1'b1, 40);
        chk_outs("b2b", 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("b2b.nint", 32'(nint - n0), 32'd2);

        // short low glitch on the idle line
        n0 = nint;
        drive_level(1'b0, 5);
        drive_level(1'b1, 40);
        chk_outs("glitch", 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("glitch.nint", 32'(nint - n0), 32'd0);

        ack_pulse();
        tick_clk();
        chk_outs("ack", 8'h3C, 1'b0, 1'b0, 1'b0);

        // rxack on the very cycle the second byte is delivered
        n0 = nint;
        send_frame(8'h11, 16, 0);
        drive_level(1'b1, 40);
        ack_on_int = 1'b1;
        send_frame(8'h22, 16, 0);
        drive_level(1'b1, 40);
        ack_on_int = 1'b0;
        bus.rxack  = 1'b0;
        chk_outs("coinc", 8'h22, 1'b1, 1'b0, 1'b0);
        chk("coinc.nint", 32'(nint - n0), 32'd2);

        // reset in the middle of the data bits
        bus.rxd = 1'b0;
        repeat (16) tick_clk();
        bus.rxd = 1'b1;
        repeat (48) tick_clk();
        rst_n = 1'b0;
        #1;
        chk_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst.rxint", 32'(bus.rxint), 32'd0);
        repeat (3) tick_clk();
        rst_n = 1'b1;
        repeat (4) tick_clk();
        n0 = nint;
        send_frame(8'h96, 16, 0);
        drive_level(1'b1, 40);
        chk_outs("postrst", 8'h96, 1'b1, 1'b0, 1'b0);
        chk("postrst.nint", 32'(nint - n0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
